shift_load_ctrl: RTL and testbench
==================================

# shift_load_ctrl

Controller that sequences the team's 4-bit serial-in shift datapath (1-bit serial input, 4-bit parallel output `r`).
- On a start request it clears the datapath and serially shifts a latched pattern in, MSB first.
- It then reads back the parallel output and reports match and clear-error status.
- It sits between a test/config master and the shift datapath, and owns the datapath's serial input, shift enable and clear.

## Interface
Parameters:
- `WIDTH`, 4, datapath width in bits (≥2)
- `BIT_CYCLES`, 1, clock cycles each serial bit is held on `a` (≥1)

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `pattern`  in  WIDTH  value to load; latched when start is accepted
- `r_in`  in  WIDTH  datapath parallel output `r`
- `a`  out  1  serial bit to datapath
- `shift_en`  out  1  datapath shifts `r <= {r[WIDTH-2:0], a}` on posedge when high
- `clr`  out  1  datapath clears `r` to 0 on posedge when high
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse in DONE
- `match`  out  1  `r_in == pattern` at CHECK; held until next accepted start
- `clr_err`  out  1  `r_in != 0` in first SHIFT cycle; held until next accepted start

## Operation
- States: IDLE, CLEAR, SHIFT, CHECK, DONE.
- IDLE, `start`=1: latch pattern, clear `match`/`clr_err`, go to CLEAR. `start` is ignored in all other states; no queuing.
- CLEAR: `clr`=1 for exactly one cycle, then go to SHIFT with `bit_idx`=WIDTH-1 and `hold_cnt`=0.
- SHIFT: `a`=pattern[bit_idx]. `hold_cnt` counts 0..BIT_CYCLES-1.
  - `shift_en`=1 only when `hold_cnt`==BIT_CYCLES-1.
  - On that cycle: if `bit_idx`==0, go to CHECK; else decrement `bit_idx` and reset `hold_cnt`.
- First SHIFT cycle (`bit_idx`=WIDTH-1, `hold_cnt`=0): register `clr_err` = |`r_in`.
- CHECK: register `match` = (`r_in` == latched pattern), then go to DONE.
- DONE: `done`=1, then go to IDLE.
- `a`=0 outside SHIFT. `shift_en`/`clr` are 0 outside their states.
- `bit_idx` width is $clog2(WIDTH); `hold_cnt` width is max(1,$clog2(BIT_CYCLES)). Neither wraps past its terminal value.
- Reset, asserted anytime including mid-shift: state goes to IDLE; all outputs go to 0 immediately (async); latched pattern goes to 0. The datapath is not cleared by this block on reset.

## Timing
- `start` accepted at edge k:
  - CLEAR occupies cycle k..k+1.
  - SHIFT occupies edges k+1 .. k+1+WIDTH·BIT_CYCLES.
  - Last shift occurs at edge k+1+WIDTH·BIT_CYCLES.
  - CHECK follows for one cycle; `match` is valid after edge k+2+WIDTH·BIT_CYCLES, together with `done`.
  - IDLE after edge k+3+WIDTH·BIT_CYCLES.
- Defaults: `done` is high 6 cycles after the accepting edge. Total busy time is 7 cycles.
- `start` held high continuously: the next run is accepted on the first IDLE cycle after DONE. There is no back-to-back run without an IDLE cycle.
- Outputs are registered (Moore) except `a`, which is decoded from the registered `bit_idx` and pattern. No combinational path from `start` or `r_in` to any output.

## Structure
- Package `shift_ctrl_pkg`:
  - `ctrl_state_t` enum (IDLE, CLEAR, SHIFT, CHECK, DONE)
  - default `WIDTH`/`BIT_CYCLES` localparams
- Sub-module `shift_hold_timer`: the `hold_cnt` counter with a `last` flag, parameterised by BIT_CYCLES. The FSM, latches and checks stay in top.

## Test plan
Bench: 20 ns clock, behavioural 4-bit shift datapath with `clr`/`shift_en`.

1. Reset: assert `rst` mid-cycle → all outputs 0 without waiting for a clock edge; state IDLE.
2. `pattern`=4'b1011, `start` 1 cycle → `a` sequence 1,0,1,1 with `shift_en` on each of 4 cycles; `r`=1011 at CHECK; `done`=1 with `match`=1 at edge +6; `clr_err`=0.
3. `BIT_CYCLES`=3, `pattern`=4'b0110 → each bit held 3 cycles; `shift_en` on every 3rd cycle only; `done` at edge +14; `match`=1.
4. Datapath fault, ignoring `clr` (r stays 4'b1111), `pattern`=4'b0000 → `clr_err`=1 at end of run. Separately, corrupt one shifted bit → `match`=0; `done` still pulses.
5. `start` pulsed during SHIFT → ignored, pattern unchanged. `start` held high → second run begins exactly one IDLE cycle after DONE.
6. `rst` asserted during SHIFT after 2 bits → IDLE, `a`/`shift_en`/`busy` = 0. Next start runs a full, correct sequence with `match`=1.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared types and defaults for the shift-load controller and its hold timer.
package shift_ctrl_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_BIT_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/shift_hold_timer.sv
// Counts how many cycles the current serial bit has been held; flags the last one.
module shift_hold_timer
  import shift_ctrl_pkg::*;
#(
  parameter int  BIT_CYCLES = DEF_BIT_CYCLES,
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             last_s;

  assign last_s = (cnt_r == CNT_MAX);

  // hold counter: saturates at its terminal value instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (restart) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (run && !last_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign last = last_s;

endmodule

// File: rtl/shift_load_ctrl.sv
// Sequences a serial-in shift datapath: clear, shift a latched pattern in MSB
// first, then read back the parallel output for match and clear-error status.
module shift_load_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] r_in,
  output logic             a,
  output logic             shift_en,
  output logic             clr,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             clr_err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  ctrl_state_t      state_r;
  ctrl_state_t      state_s;
  logic [WIDTH-1:0] pat_r;
  logic [IDX_W-1:0] bit_idx_r;
  logic [CNT_W-1:0] hold_cnt_s;
  logic             last_s;
  logic             accept_s;
  logic             restart_s;
  logic             run_s;
  logic             match_r;
  logic             clr_err_r;

  assign accept_s  = (state_r == IDLE) && start;
  assign run_s     = (state_r == SHIFT);
  assign restart_s = (state_r == CLEAR) || ((state_r == SHIFT) && last_s);

  shift_hold_timer #(.BIT_CYCLES(BIT_CYCLES)) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_s),
    .run     (run_s),
    .cnt     (hold_cnt_s),
    .last    (last_s)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CLEAR;
        else       state_s = IDLE;
      end
      CLEAR: state_s = SHIFT;
      SHIFT: begin
        if (last_s && (bit_idx_r == {IDX_W{1'b0}})) state_s = CHECK;
        else                                        state_s = SHIFT;
      end
      CHECK:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // pattern latch and bit index, walking MSB to LSB without wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r     <= {WIDTH{1'b0}};
      bit_idx_r <= {IDX_W{1'b0}};
    end else begin
      if (accept_s) pat_r <= pattern;
      else          pat_r <= pat_r;
      if (state_r == CLEAR)
        bit_idx_r <= IDX_TOP;
      else if (run_s && last_s && (bit_idx_r != {IDX_W{1'b0}}))
        bit_idx_r <= bit_idx_r - IDX_W'(1);
      else
        bit_idx_r <= bit_idx_r;
    end
  end

  // status flags: cleared on accept, sampled from the datapath at fixed points
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_r   <= 1'b0;
      clr_err_r <= 1'b0;
    end else if (accept_s) begin
      match_r   <= 1'b0;
      clr_err_r <= 1'b0;
    end else begin
      if (run_s && (bit_idx_r == IDX_TOP) && (hold_cnt_s == {CNT_W{1'b0}}))
        clr_err_r <= |r_in;
      else
        clr_err_r <= clr_err_r;
      if (state_r == CHECK) match_r <= (r_in == pat_r);
      else                  match_r <= match_r;
    end
  end

  // Moore output decode from registered state, index and hold counter
  always_comb begin
    a        = 1'b0;
    shift_en = 1'b0;
    clr      = 1'b0;
    done     = 1'b0;
    busy     = (state_r != IDLE);
    case (state_r)
      CLEAR: clr = 1'b1;
      SHIFT: begin
        a        = pat_r[bit_idx_r];
        shift_en = last_s;
      end
      DONE:    done = 1'b1;
      default: begin
        a        = 1'b0;
        shift_en = 1'b0;
      end
    endcase
  end

  assign match   = match_r;
  assign clr_err = clr_err_r;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Randomized self-checking bench: two controllers (1 and 3 cycles per bit), each
// driving a behavioural 4-bit shift datapath with injectable clear/bit faults.
module tb_shift_load_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic         start_s   [2];
  logic [W-1:0] pattern_s [2];
  logic [W-1:0] r_s       [2];
  logic         ign_s     [2];
  int           flip_s    [2];
  int           shcnt_s   [2];
  logic [1:0]   a_v, se_v, clr_v, busy_v, done_v, match_v, cerr_v;

  always #10 clk = ~clk;

  shift_load_ctrl #(.WIDTH(W), .BIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .pattern(pattern_s[0]), .r_in(r_s[0]),
    .a(a_v[0]), .shift_en(se_v[0]), .clr(clr_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .match(match_v[0]), .clr_err(cerr_v[0]));

  shift_load_ctrl #(.WIDTH(W), .BIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .pattern(pattern_s[1]), .r_in(r_s[1]),
    .a(a_v[1]), .shift_en(se_v[1]), .clr(clr_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .match(match_v[1]), .clr_err(cerr_v[1]));

  // behavioural datapaths; optional ignored clear and one flipped shifted bit
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (clr_v[g]) begin
        shcnt_s[g] <= 0;
        if (!ign_s[g]) r_s[g] <= '0;
      end else if (se_v[g]) begin
        r_s[g]     <= {r_s[g][W-2:0], a_v[g] ^ (shcnt_s[g] == flip_s[g])};
        shcnt_s[g] <= shcnt_s[g] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_tests++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic logic [4:0] outs(input int g);
    return {busy_v[g], clr_v[g], se_v[g], a_v[g], done_v[g]};
  endfunction

  // expected {busy,clr,shift_en,a,done} c cycles after the accepting edge
  function automatic logic [4:0] exp_outs(input int c, input int bc, input logic [W-1:0] pat);
    logic b, cl, se, av, dn;
    int j, h;
    b = 1'b1; cl = 1'b0; se = 1'b0; av = 1'b0; dn = 1'b0;
    if (c == 0) begin
      cl = 1'b1;
    end else if (c <= W * bc) begin
      j  = (c - 1) / bc;
      h  = (c - 1) % bc;
      av = pat[W-1-j];
      se = (h == bc - 1);
    end else if (c == W * bc + 2) begin
      dn = 1'b1;
    end else if (c > W * bc + 2) begin
      b = 1'b0;
    end
    return {b, cl, se, av, dn};
  endfunction

  task automatic run_once(input int g, input logic [W-1:0] pat, input logic ign,
                          input int flip, input bit poke, input bit hold);
    int bc;
    int n;
    logic [W-1:0] r_prev, exp_r;
    bc = (g == 0) ? 1 : 3;
    n  = W * bc;
    ign_s[g]  = ign;
    flip_s[g] = flip;
    @(negedge clk);
    pattern_s[g] = pat;
    start_s[g]   = 1'b1;
    @(negedge clk);
    if (!hold) start_s[g] = 1'b0;
    r_prev = r_s[g];
    exp_r  = pat;
    if (flip >= 0) exp_r[W-1-flip] = ~exp_r[W-1-flip];
    for (int c = 0; c <= n + 3; c++) begin
      if (c > 0) @(negedge clk);
      check_eq($sformatf("g%0d p%0h c%0d outs", g, pat, c), 32'(outs(g)), 32'(exp_outs(c, bc, pat)));
      if (c >= n + 2) begin
        check_eq($sformatf("g%0d p%0h c%0d match", g, pat, c), 32'(match_v[g]), 32'(exp_r == pat));
        check_eq($sformatf("g%0d p%0h c%0d clr_err", g, pat, c), 32'(cerr_v[g]),
                 32'(ign ? |r_prev : 1'b0));
      end
      if (poke && c == 2) begin
        start_s[g]   = 1'b1;
        pattern_s[g] = ~pat;
      end
      if (poke && c == 3) start_s[g] = 1'b0;
    end
    if (hold) begin
      @(negedge clk);
      check_eq($sformatf("g%0d held start rerun", g), 32'(outs(g)), 32'(exp_outs(0, bc, pat)));
      start_s[g] = 1'b0;
      for (int i = 0; i < 60 && busy_v[g]; i++) @(negedge clk);
      check_eq($sformatf("g%0d rerun idle", g), 32'(busy_v[g]), 32'd0);
      check_eq($sformatf("g%0d rerun match", g), 32'(match_v[g]), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0; pattern_s[g] = '0; ign_s[g] = 1'b0; flip_s[g] = -1;
    end
    // reset before any clock edge: outputs must drop asynchronously
    #3 rst = 1'b1;
    #1;
    check_eq("por outs0", 32'({outs(0), match_v[0], cerr_v[0]}), 32'd0);
    check_eq("por outs1", 32'({outs(1), match_v[1], cerr_v[1]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_once(0, 4'b1011, 1'b0, -1, 1'b0, 1'b0);
    run_once(1, 4'b0110, 1'b0, -1, 1'b0, 1'b0);
    run_once(0, 4'b1111, 1'b0, -1, 1'b0, 1'b0);
    run_once(0, 4'b0000, 1'b1, -1, 1'b0, 1'b0);
    run_once(0, 4'b1011, 1'b0, 2, 1'b0, 1'b0);
    run_once(1, 4'b1001, 1'b0, 0, 1'b0, 1'b0);
    run_once(0, 4'b1100, 1'b0, -1, 1'b1, 1'b0);
    run_once(0, 4'b0101, 1'b0, -1, 1'b0, 1'b1);

    // reset mid-shift, after two bits have gone in
    @(negedge clk);
    pattern_s[0] = 4'b1101;
    start_s[0]   = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst outs0", 32'({outs(0), match_v[0], cerr_v[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_once(0, 4'b1101, 1'b0, -1, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      int   g;
      logic [W-1:0] p;
      logic ign;
      int   flip;
      bit   poke;
      g    = $urandom_range(0, 1);
      p    = W'($urandom);
      ign  = ($urandom_range(0, 3) == 0);
      flip = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      poke = $urandom_range(0, 1);
      run_once(g, p, ign, flip, poke, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
